// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART frame constants, parity modes and TX state encoding.
package uart_pkg;

  localparam int FRAME_BITS = 11;
  localparam logic STOP_LEVEL = 1'b1;
  localparam logic START_LEVEL = 1'b0;

  // Parity mode selectors, indexed by {eight, pen}
  localparam logic [1:0] MODE_7N = 2'b00;
  localparam logic [1:0] MODE_7P = 2'b01;
  localparam logic [1:0] MODE_8N = 2'b10;
  localparam logic [1:0] MODE_8P = 2'b11;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    LOADING  = 2'b01,
    SHIFTING = 2'b10
  } tx_state_e;

  function automatic logic parity_bit(input logic [7:0] bits, input logic odd);
    return (^bits) ^ odd;
  endfunction

endpackage

// File: rtl/tx_frame_builder.sv
// rtl/tx_frame_builder.sv - combinational 11-bit frame assembly (start, data, parity, stop), LSB first.
module tx_frame_builder
  import uart_pkg::*;
(
  input  logic [7:0]            data,
  input  logic                  eight,
  input  logic                  pen,
  input  logic                  ohel,
  output logic [FRAME_BITS-1:0] frame
);

  logic b8;
  logic b9;

  always_comb begin
    b8 = STOP_LEVEL;
    b9 = STOP_LEVEL;
    case ({eight, pen})
      MODE_8P: begin
        b8 = data[7];
        b9 = parity_bit(data, ohel);
      end
      MODE_8N: b8 = data[7];
      MODE_7P: b8 = parity_bit({1'b0, data[6:0]}, ohel);
      default: begin
        b8 = STOP_LEVEL;
        b9 = STOP_LEVEL;
      end
    endcase
    frame = {STOP_LEVEL, b9, b8, data[6:0], START_LEVEL};
  end

endmodule

// File: rtl/uart_tx_shift_control.sv
// rtl/uart_tx_shift_control.sv - UART TX control: accepts a CPU byte, shifts the frame out per btu,
// hands back tx_rdy when bit_counter reports done.
module uart_tx_shift_control #(
  parameter int FRAME_BITS = 11,
  parameter int DATA_W     = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] data_in,
  input  logic              eight,
  input  logic              pen,
  input  logic              ohel,
  input  logic              btu,
  input  logic              done,
  output logic              doit,
  output logic              tx,
  output logic              tx_rdy,
  output logic              tx_rdy_pulse
);

  import uart_pkg::*;

  tx_state_e               state_q, state_d;
  logic [FRAME_BITS-1:0]   shift_q, shift_d;
  logic [DATA_W-1:0]       data_q, data_d;
  logic                    eight_q, eight_d;
  logic                    pen_q, pen_d;
  logic                    ohel_q, ohel_d;
  logic                    doit_q, doit_d;
  logic                    tx_rdy_q, tx_rdy_d;
  logic                    pulse_q, pulse_d;
  logic [FRAME_BITS-1:0]   frame;

  tx_frame_builder u_frame (
    .data  (data_q[7:0]),
    .eight (eight_q),
    .pen   (pen_q),
    .ohel  (ohel_q),
    .frame (frame)
  );

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    data_d   = data_q;
    eight_d  = eight_q;
    pen_d    = pen_q;
    ohel_d   = ohel_q;
    doit_d   = doit_q;
    tx_rdy_d = tx_rdy_q;
    pulse_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (load && tx_rdy_q) begin
          data_d   = data_in;
          eight_d  = eight;
          pen_d    = pen;
          ohel_d   = ohel;
          tx_rdy_d = 1'b0;
          state_d  = LOADING;
        end
      end
      LOADING: begin
        shift_d = frame;
        doit_d  = 1'b1;
        state_d = SHIFTING;
      end
      SHIFTING: begin
        // done has priority over a coincident btu so the line never moves on the last edge
        if (done) begin
          shift_d  = '1;
          doit_d   = 1'b0;
          tx_rdy_d = 1'b1;
          pulse_d  = 1'b1;
          state_d  = IDLE;
        end else if (btu) begin
          shift_d = {STOP_LEVEL, shift_q[FRAME_BITS-1:1]};
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      shift_q  <= '1;
      data_q   <= '0;
      eight_q  <= 1'b0;
      pen_q    <= 1'b0;
      ohel_q   <= 1'b0;
      doit_q   <= 1'b0;
      tx_rdy_q <= 1'b1;
      pulse_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      data_q   <= data_d;
      eight_q  <= eight_d;
      pen_q    <= pen_d;
      ohel_q   <= ohel_d;
      doit_q   <= doit_d;
      tx_rdy_q <= tx_rdy_d;
      pulse_q  <= pulse_d;
    end
  end

  assign tx           = shift_q[0];
  assign doit         = doit_q;
  assign tx_rdy       = tx_rdy_q;
  assign tx_rdy_pulse = pulse_q;

endmodule

// File: doc/uart_tx_shift_control.md
Name: uart_tx_shift_control

Overview:
Transmit-side control and datapath stage of the UART TX. It accepts a byte write from the TramelBlaze and builds an 11-bit serial frame: start bit, data, optional parity, and stop/idle bits. It drives doit to the downstream bit_counter and shifts the frame out on each btu. When bit_counter reports done, it ends the frame and returns tx_rdy to the CPU.

Parameters:
FRAME_BITS, 11, number of bit periods per frame; must match the bit_counter done count.
DATA_W, 8, width of the CPU write data.

Ports:
clock  input  1  system clock; all state updates on rising edge.
reset  input  1  asynchronous, active-low reset. 0 = reset asserted. Must not be synchronised away.
load  input  1  one-cycle write strobe from the CPU port decode.
data_in  input  DATA_W  byte to transmit; sampled only when a load is accepted.
eight  input  1  1 = 8 data bits; 0 = 7 data bits.
pen  input  1  parity enable.
ohel  input  1  parity sense: 1 = odd, 0 = even.
btu  input  1  one-cycle bit-time-up tick from the bit time counter.
done  input  1  from bit_counter; high when FRAME_BITS bit periods have elapsed.
doit  output  1  frame in progress; enables bit_counter and the bit time counter.
tx  output  1  serial line; idle level is 1.
tx_rdy  output  1  level; 1 = ready to accept a load.
tx_rdy_pulse  output  1  one-cycle pulse when a frame completes; feeds the CPU interrupt.

Behaviour:
- Reset (reset = 0, asynchronous): doit = 0, tx = 1, tx_rdy = 1, tx_rdy_pulse = 0, shift register = all 1s.
- Accept rule: a load is accepted only when tx_rdy = 1. A load while tx_rdy = 0 is ignored; no state changes and nothing is queued.
- Accept cycle N (load = 1 and tx_rdy = 1 at edge N):
  - data_in and the eight/pen/ohel settings are latched at edge N.
  - tx_rdy = 0 after edge N.
- Cycle N+1:
  - doit = 1.
  - Shift register is loaded with the frame, bit 0 first: {1, b9, b8, data[6:0], 0}.
  - tx shows the start bit (0).
- Bits b8/b9 by mode:
  - eight = 1, pen = 1: b8 = data[7], b9 = parity over data[7:0].
  - eight = 1, pen = 0: b8 = data[7], b9 = 1.
  - eight = 0, pen = 1: b8 = parity over data[6:0], b9 = 1.
  - eight = 0, pen = 0: b8 = 1, b9 = 1.
- Parity: even = XOR of the selected data bits; odd = inverted XOR.
- Shifting:
  - tx = shift register bit 0, registered; no glitch path from inputs.
  - Each btu while doit = 1 and done = 0 shifts the register right by one and fills the MSB with 1.
- End of frame: on the first edge where done = 1 and doit = 1:
  - doit = 0, tx_rdy = 1, tx_rdy_pulse = 1 for exactly one cycle.
  - tx stays 1.
- Simultaneous events:
  - done and btu in the same cycle: done wins and no shift occurs.
  - load in the same cycle as done: ignored, because tx_rdy is still 0.
  - A load is accepted at the earliest on the cycle after tx_rdy rises.
- btu while doit = 0 has no effect.
- Reset mid-frame: tx returns to 1 immediately without waiting for a clock edge, and the frame is abandoned. bit_counter clears because doit = 0.
- State machine:
  - IDLE → LOADING on an accepted load.
  - LOADING → SHIFTING unconditionally after one cycle.
  - SHIFTING → IDLE on done.
- Frame time: FRAME_BITS btu periods, plus 1 cycle of load latency, plus 1 cycle of done-to-idle latency.

Decomposition:
- Shared uart_pkg holds:
  - FRAME_BITS = 11, STOP_LEVEL = 1, START_LEVEL = 0.
  - Parity-mode constants for {eight, pen}.
  - State encoding IDLE/LOADING/SHIFTING.
- Sub-module tx_frame_builder is natural: purely combinational, takes data, eight, pen, ohel and returns the 11-bit frame. It is reused by RX-side parity checking.

Test Plan:
1. Reset released, no load → tx = 1, doit = 0, tx_rdy = 1 held for 100 cycles; btu pulses have no effect.
2. eight = 1, pen = 0, load 0x55 → doit at N+1; tx per btu = 0,1,0,1,0,1,0,1,0,1,1; tx_rdy_pulse one cycle after the 11th btu.
3. eight = 1, pen = 1, ohel = 0, load 0xA5 → tx sequence 0,1,0,1,0,0,1,0,1,0,1 (even parity = 0).
4. eight = 0, pen = 1, ohel = 1, load 0x41 → tx sequence 0,1,0,0,0,0,0,1,1,1,1 (odd parity = 1 at b8).
5. Load 0x12 during a frame, and again in the cycle done rises → both ignored; the frame in flight is unchanged; a load of 0x34 one cycle after tx_rdy rises is accepted.
6. reset = 0 asserted between clock edges after the 4th btu → tx = 1 and doit = 0 before the next edge; tx_rdy = 1; a new load after release produces a full, clean frame.
